// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and constants for the 2x2 systolic feeder
package matmul_pkg;

  localparam int DEFAULT_DATA_W = 32;

  // A 2x2 product needs three skewed beats to push every operand into the array.
  localparam int SKEW_BEATS = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/systolic_2x2_feeder.sv
// rtl/systolic_2x2_feeder.sv - captures a 2x2 matrix pair and streams it skewed into a systolic array
module systolic_2x2_feeder
  import matmul_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a00,
  input  logic [DATA_W-1:0] a01,
  input  logic [DATA_W-1:0] a10,
  input  logic [DATA_W-1:0] a11,
  input  logic [DATA_W-1:0] b00,
  input  logic [DATA_W-1:0] b01,
  input  logic [DATA_W-1:0] b10,
  input  logic [DATA_W-1:0] b11,
  output logic [DATA_W-1:0] mat1_row0,
  output logic [DATA_W-1:0] mat1_row1,
  output logic [DATA_W-1:0] mat2_col0,
  output logic [DATA_W-1:0] mat2_col1,
  output logic              load_out,
  output logic              busy,
  output logic              done
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [1:0] BEAT_LAST = 2'(SKEW_BEATS - 1);
  localparam logic [DATA_W-1:0] ZERO = '0;

  typedef logic [SKEW_BEATS-1:0][DATA_W-1:0] lane_t;

  state_t             state, state_next;
  logic [1:0]         beat, beat_next;
  logic [DRAIN_W-1:0] drain, drain_next;
  logic               take;

  // The operand registers are the skew shift registers themselves: element [0]
  // drives the lane, and zeros shift in behind the last real operand.
  lane_t row0_sr, row1_sr, col0_sr, col1_sr;

  assign take = (state == ST_IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      beat  <= '0;
      drain <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
      drain <= drain_next;
    end
  end

  always_comb begin
    state_next = state;
    beat_next  = beat;
    drain_next = drain;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = ST_FEED;
          beat_next  = '0;
        end
      end
      ST_FEED: begin
        if (beat == BEAT_LAST) begin
          beat_next  = '0;
          drain_next = '0;
          state_next = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        end else begin
          beat_next = beat + 2'd1;
        end
      end
      ST_DRAIN: begin
        if (drain == DRAIN_LAST) begin
          drain_next = '0;
          state_next = ST_DONE;
        end else begin
          drain_next = drain + DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Beat 0 is loaded straight from the inputs so it is visible right after the transfer edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row0_sr <= '0;
      row1_sr <= '0;
      col0_sr <= '0;
      col1_sr <= '0;
    end else if (take) begin
      row0_sr <= {ZERO, a01, a00};
      row1_sr <= {a11, a10, ZERO};
      col0_sr <= {ZERO, b10, b00};
      col1_sr <= {b11, b01, ZERO};
    end else if (state != ST_IDLE) begin
      row0_sr <= {ZERO, row0_sr[SKEW_BEATS-1:1]};
      row1_sr <= {ZERO, row1_sr[SKEW_BEATS-1:1]};
      col0_sr <= {ZERO, col0_sr[SKEW_BEATS-1:1]};
      col1_sr <= {ZERO, col1_sr[SKEW_BEATS-1:1]};
    end
  end

  assign mat1_row0 = row0_sr[0];
  assign mat1_row1 = row1_sr[0];
  assign mat2_col0 = col0_sr[0];
  assign mat2_col1 = col1_sr[0];

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign load_out = (state == ST_FEED) || (state == ST_DRAIN);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_systolic_2x2_feeder.sv
// tb/tb_systolic_2x2_feeder.sv - randomized self-checking bench for systolic_2x2_feeder
module tb_systolic_2x2_feeder;
  localparam int W = 32;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_valid0;
  logic [W-1:0] a00, a01, a10, a11, b00, b01, b10, b11;

  logic in_ready, load_out, busy, done;
  logic [W-1:0] row0, row1, col0, col1;
  logic in_ready_z, load_out_z, busy_z, done_z;
  logic [W-1:0] row0_z, row1_z, col0_z, col1_z;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] ma[2][2];
  logic [W-1:0] mb[2][2];

  always #5 clk = ~clk;

  systolic_2x2_feeder #(.DATA_W(W), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .mat1_row0(row0), .mat1_row1(row1), .mat2_col0(col0), .mat2_col1(col1),
    .load_out(load_out), .busy(busy), .done(done)
  );

  systolic_2x2_feeder #(.DATA_W(W), .DRAIN_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready_z),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .mat1_row0(row0_z), .mat1_row1(row1_z), .mat2_col0(col0_z), .mat2_col1(col1_z),
    .load_out(load_out_z), .busy(busy_z), .done(done_z)
  );

  // Skew rule: row i carries A[i][t-i], column j carries B[t-j][j], zero outside.
  function automatic logic [W-1:0] exp_row(input logic [W-1:0] m[2][2], input int i, input int t);
    int k = t - i;
    if (k >= 0 && k < 2) return m[i][k];
    return '0;
  endfunction

  function automatic logic [W-1:0] exp_col(input logic [W-1:0] m[2][2], input int j, input int t);
    int k = t - j;
    if (k >= 0 && k < 2) return m[k][j];
    return '0;
  endfunction

  task automatic drive_operands();
    a00 = ma[0][0]; a01 = ma[0][1]; a10 = ma[1][0]; a11 = ma[1][1];
    b00 = mb[0][0]; b01 = mb[0][1]; b10 = mb[1][0]; b11 = mb[1][1];
  endtask

  task automatic randomize_pair();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ma[i][j] = $urandom;
        mb[i][j] = $urandom;
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
    ma = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}};
    mb = ma;
    drive_operands();
    step(); step();
    checks++;
    if ({row0, row1, col0, col1} !== '0 || {load_out, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got streams=%h ctl=%b expected 0", {row0, row1, col0, col1}, {load_out, busy, done});
    end
    checks++;
    if ({row0_z, row1_z, col0_z, col1_z} !== '0 || {load_out_z, busy_z, done_z} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs_d0: got ctl=%b expected 000", {load_out_z, busy_z, done_z});
    end
    @(negedge clk); rst = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || in_ready_z !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b%b expected 11", in_ready, in_ready_z);
    end
  endtask

  task automatic test_single_pair();
    logic [W-1:0] obs_r[2][8];
    logic [W-1:0] obs_c[2][8];
    logic [63:0] acc;
    logic [63:0] want[2][2];
    ma = '{'{32'd1, 32'd2}, '{32'd3, 32'd4}};
    mb = '{'{32'd5, 32'd6}, '{32'd7, 32'd8}};
    want = '{'{64'd19, 64'd22}, '{64'd43, 64'd50}};
    drive_operands();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 8; t++) begin
      obs_r[0][t] = row0; obs_r[1][t] = row1; obs_c[0][t] = col0; obs_c[1][t] = col1;
      checks++;
      if ({row0, row1, col0, col1} !== {exp_row(ma, 0, t), exp_row(ma, 1, t), exp_col(mb, 0, t), exp_col(mb, 1, t)}) begin
        errors++;
        $display("FAIL single_stream t=%0d: got %h %h %h %h expected %h %h %h %h", t, row0, row1, col0, col1,
                 exp_row(ma, 0, t), exp_row(ma, 1, t), exp_col(mb, 0, t), exp_col(mb, 1, t));
      end
      checks++;
      if ({load_out, busy, done, in_ready} !== {t < 3 + D, t <= 3 + D, t == 3 + D, t > 3 + D}) begin
        errors++;
        $display("FAIL single_ctl t=%0d: got load/busy/done/ready=%b expected %b", t, {load_out, busy, done, in_ready},
                 {t < 3 + D, t <= 3 + D, t == 3 + D, t > 3 + D});
      end
      step();
    end
    // A downstream PE(i,j) sees row i delayed by j and column j delayed by i.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc = '0;
        for (int t = 0; t < 8; t++)
          if (t - j >= 0 && t - i >= 0) acc += 64'(obs_r[i][t - j]) * 64'(obs_c[j][t - i]);
        checks++;
        if (acc !== want[i][j]) begin
          errors++;
          $display("FAIL array_result c%0d%0d: got %0d expected %0d", i, j, acc, want[i][j]);
        end
      end
  endtask

  task automatic test_random_pairs();
    logic [W-1:0] obs_r[2][8];
    logic [W-1:0] obs_c[2][8];
    logic [63:0] acc, ref_v;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) begin
        ma = '{'{32'hFFFFFFFF, 32'hFFFFFFFF}, '{32'hFFFFFFFF, 32'hFFFFFFFF}};
        mb = ma;
      end else begin
        randomize_pair();
      end
      drive_operands();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      randomize_pair();
      drive_operands();
      if (n == 0) begin
        ma = '{'{32'hFFFFFFFF, 32'hFFFFFFFF}, '{32'hFFFFFFFF, 32'hFFFFFFFF}};
        mb = ma;
      end else begin
        ma = '{'{a00 ^ a00, 32'h0}, '{32'h0, 32'h0}};
      end
      if (n != 0) begin
        // inputs were scrambled after capture; rebuild the expected pair from nothing the DUT produced
        ma = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}};
      end
      for (int t = 0; t < 8; t++) begin
        obs_r[0][t] = row0; obs_r[1][t] = row1; obs_c[0][t] = col0; obs_c[1][t] = col1;
        step();
      end
      if (n == 0) begin
        for (int t = 0; t < 8; t++) begin
          checks++;
          if ({obs_r[0][t], obs_r[1][t], obs_c[0][t], obs_c[1][t]} !==
              {exp_row(ma, 0, t), exp_row(ma, 1, t), exp_col(mb, 0, t), exp_col(mb, 1, t)}) begin
            errors++;
            $display("FAIL all_ones t=%0d: got %h %h %h %h", t, obs_r[0][t], obs_r[1][t], obs_c[0][t], obs_c[1][t]);
          end
        end
      end
    end
    for (int n = 0; n < 6; n++) begin
      randomize_pair();
      drive_operands();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int t = 0; t < 8; t++) begin
        obs_r[0][t] = row0; obs_r[1][t] = row1; obs_c[0][t] = col0; obs_c[1][t] = col1;
        checks++;
        if ({row0, row1, col0, col1} !== {exp_row(ma, 0, t), exp_row(ma, 1, t), exp_col(mb, 0, t), exp_col(mb, 1, t)}) begin
          errors++;
          $display("FAIL random_stream n=%0d t=%0d: got %h %h %h %h", n, t, row0, row1, col0, col1);
        end
        step();
      end
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          acc = '0;
          for (int t = 0; t < 8; t++)
            if (t - j >= 0 && t - i >= 0) acc += 64'(obs_r[i][t - j]) * 64'(obs_c[j][t - i]);
          ref_v = 64'(ma[i][0]) * 64'(mb[0][j]) + 64'(ma[i][1]) * 64'(mb[1][j]);
          checks++;
          if (acc !== ref_v) begin
            errors++;
            $display("FAIL random_product n=%0d c%0d%0d: got %h expected %h", n, i, j, acc, ref_v);
          end
        end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] fa[2][2];
    logic [W-1:0] fb[2][2];
    randomize_pair();
    drive_operands();
    fa = ma; fb = mb;
    in_valid = 1'b1;
    step();
    randomize_pair();
    drive_operands();
    for (int t = 0; t < 11; t++) begin
      if (t < 3) begin
        checks++;
        if ({row0, row1, col0, col1} !== {exp_row(fa, 0, t), exp_row(fa, 1, t), exp_col(fb, 0, t), exp_col(fb, 1, t)}) begin
          errors++;
          $display("FAIL b2b_first t=%0d: got %h %h %h %h", t, row0, row1, col0, col1);
        end
      end
      if (t < 7) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready t=%0d: got %b expected 0", t, in_ready);
        end
      end
      if (t == 7) begin
        checks++;
        if ({load_out, busy} !== 2'b00) begin
          errors++;
          $display("FAIL b2b_gap: got load/busy=%b expected 00", {load_out, busy});
        end
      end
      if (t >= 8) begin
        checks++;
        if ({load_out, row0, row1, col0, col1} !==
            {1'b1, exp_row(ma, 0, t - 8), exp_row(ma, 1, t - 8), exp_col(mb, 0, t - 8), exp_col(mb, 1, t - 8)}) begin
          errors++;
          $display("FAIL b2b_second t=%0d: got load=%b %h %h %h %h", t, load_out, row0, row1, col0, col1);
        end
      end
      step();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 6; t++) step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_ignore_drain();
    randomize_pair();
    drive_operands();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 9; t++) begin
      if (t == 3) begin
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) begin
            a00 = $urandom | 32'h1; b11 = $urandom | 32'h1;
          end
        in_valid = 1'b1;
      end
      if (t == 4) in_valid = 1'b0;
      checks++;
      if ({row0, row1, col0, col1, load_out, done, busy} !==
          {exp_row(ma, 0, t), exp_row(ma, 1, t), exp_col(mb, 0, t), exp_col(mb, 1, t), t < 3 + D, t == 3 + D, t <= 3 + D}) begin
        errors++;
        $display("FAIL drain_ignore t=%0d: got %h %h %h %h load/done/busy=%b", t, row0, row1, col0, col1, {load_out, done, busy});
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    randomize_pair();
    drive_operands();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({row0, row1, col0, col1} !== '0 || {load_out, busy, done, in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_async: got streams=%h ctl=%b expected 0 / 0001", {row0, row1, col0, col1},
               {load_out, busy, done, in_ready});
    end
    step();
    @(negedge clk); rst = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step();
      checks++;
      if ({done, busy, load_out, in_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL reset_mid_after t=%0d: got done/busy/load/ready=%b expected 0001", t, {done, busy, load_out, in_ready});
      end
    end
  endtask

  task automatic test_drain_zero();
    randomize_pair();
    drive_operands();
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    for (int t = 0; t < 6; t++) begin
      checks++;
      if ({load_out_z, done_z, busy_z, row0_z, row1_z, col0_z, col1_z} !==
          {t < 3, t == 3, t <= 3, exp_row(ma, 0, t), exp_row(ma, 1, t), exp_col(mb, 0, t), exp_col(mb, 1, t)}) begin
        errors++;
        $display("FAIL drain_zero t=%0d: got load/done/busy=%b %h %h %h %h", t, {load_out_z, done_z, busy_z},
                 row0_z, row1_z, col0_z, col1_z);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL drain_zero_other t=%0d: got busy=%b expected 0", t, busy);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_random_pairs();
    test_back_to_back();
    test_ignore_drain();
    test_reset_mid();
    test_drain_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
